// File: rtl/bcd_score_keeper.sv
// bcd_score_keeper: multi-channel BCD score accumulator with high score
// tracking and a once-per-game extra-life pulse. Event rising edges become
// pending requests that are served lowest channel first, one per cycle.
module bcd_score_keeper #(
  parameter int DIGITS     = 4,
  parameter int NUM_EVENTS = 4,
  parameter logic [NUM_EVENTS*4*DIGITS-1:0] POINTS = {16'h0100, 16'h0200, 16'h0050, 16'h0010},
  parameter logic [4*DIGITS-1:0] EXTRA_LIFE = 16'h1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  game_over,
  input  logic [NUM_EVENTS-1:0] event_in,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   high_score,
  output logic                  extra_life,
  output logic                  saturated,
  output logic                  busy
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [NUM_EVENTS-1:0] prev_r;
  logic [NUM_EVENTS-1:0] pending_r;
  logic [W-1:0]          score_r;
  logic [W-1:0]          high_r;
  logic                  awarded_r;
  logic                  extra_life_r;

  logic [NUM_EVENTS-1:0] rise_s;
  logic [NUM_EVENTS-1:0] grant_s;
  logic                  found_s;
  logic [W-1:0]          points_s;
  logic [W:0]            sum_s;
  logic [W-1:0]          added_s;
  logic [NUM_EVENTS-1:0] pending_next_s;
  logic [W-1:0]          score_next_s;

  // Ripple BCD adder; returns {final carry, digit sum}.
  function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] sum;
    logic         carry;
    logic [4:0]   d;
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'b0000, carry};
      if (d > 5'd9) begin
        sum[i*4 +: 4] = 4'(d - 5'd10);
        carry         = 1'b1;
      end else begin
        sum[i*4 +: 4] = d[3:0];
        carry         = 1'b0;
      end
    end
    return {carry, sum};
  endfunction

  assign rise_s = event_in & ~prev_r;

  // Fixed-priority arbiter: lowest-index pending channel wins and supplies its points.
  always_comb begin
    grant_s  = '0;
    points_s = '0;
    found_s  = 1'b0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (!found_s && pending_r[i]) begin
        grant_s[i] = 1'b1;
        points_s   = POINTS[i*W +: W];
        found_s    = 1'b1;
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  // Saturating add of the granted channel's points to the current score.
  always_comb begin
    sum_s   = bcd_add(score_r, points_s);
    added_s = sum_s[W] ? ALL_NINES : sum_s[W-1:0];
  end

  // Next pending set and score: clear beats game_over beats normal scoring.
  always_comb begin
    pending_next_s = pending_r;
    score_next_s   = score_r;
    if (clear) begin
      pending_next_s = '0;
      score_next_s   = '0;
    end else if (game_over) begin
      pending_next_s = '0;
      score_next_s   = score_r;
    end else begin
      // A rise on the channel being served re-arms it, so no award is lost.
      pending_next_s = (pending_r & ~grant_s) | rise_s;
      score_next_s   = found_s ? added_s : score_r;
    end
  end

  // Edge-detect history, pending requests and score.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_r    <= '0;
      pending_r <= '0;
      score_r   <= '0;
    end else begin
      prev_r    <= event_in;
      pending_r <= pending_next_s;
      score_r   <= score_next_s;
    end
  end

  // High score tracks the registered score; BCD compares like unsigned binary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_r <= '0;
    end else if (score_r > high_r) begin
      high_r <= score_r;
    end else begin
      high_r <= high_r;
    end
  end

  // One extra-life pulse per game on the first cycle the score reaches the threshold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      awarded_r    <= 1'b0;
      extra_life_r <= 1'b0;
    end else if (clear) begin
      awarded_r    <= 1'b0;
      extra_life_r <= 1'b0;
    end else if ((EXTRA_LIFE != '0) && !awarded_r && (score_r >= EXTRA_LIFE)) begin
      awarded_r    <= 1'b1;
      extra_life_r <= 1'b1;
    end else begin
      awarded_r    <= awarded_r;
      extra_life_r <= 1'b0;
    end
  end

  assign score      = score_r;
  assign high_score = high_r;
  assign extra_life = extra_life_r;
  assign saturated  = (score_r == ALL_NINES);
  assign busy       = |pending_r;

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Self-checking bench for bcd_score_keeper: directed scenarios followed by a
// random phase, all compared against an integer-arithmetic reference model.
module tb_bcd_score_keeper;

  localparam int MAXV = 9999;
  localparam int EL   = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        game_over;
  logic [3:0]  event_in;
  logic [15:0] score;
  logic [15:0] high_score;
  logic        extra_life;
  logic        saturated;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Reference model state in plain decimal integers.
  int       pts [4] = '{10, 50, 200, 100};
  int       m_score;
  int       m_high;
  bit [3:0] m_pend;
  bit [3:0] m_prev;
  bit       m_aw;
  bit       m_xl;

  bcd_score_keeper dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .game_over  (game_over),
    .event_in   (event_in),
    .score      (score),
    .high_score (high_score),
    .extra_life (extra_life),
    .saturated  (saturated),
    .busy       (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_score = 0;
    m_high  = 0;
    m_pend  = 4'b0000;
    m_prev  = 4'b0000;
    m_aw    = 1'b0;
    m_xl    = 1'b0;
  endtask

  task automatic check_model();
    chk("score",      score,      to_bcd(m_score));
    chk("high_score", high_score, to_bcd(m_high));
    chk("extra_life", {15'd0, extra_life}, {15'd0, m_xl});
    chk("saturated",  {15'd0, saturated},  {15'd0, (m_score == MAXV)});
    chk("busy",       {15'd0, busy},       {15'd0, (m_pend != 4'b0000)});
  endtask

  // One clock: predict from pre-edge inputs, wait past the edge, compare.
  task automatic tick();
    int       n_score;
    int       n_high;
    bit [3:0] n_pend;
    bit [3:0] n_prev;
    bit [3:0] rise;
    bit       n_aw;
    bit       n_xl;
    bit       found;
    rise    = event_in & ~m_prev;
    n_prev  = event_in;
    n_high  = (m_score > m_high) ? m_score : m_high;
    n_score = m_score;
    n_pend  = m_pend;
    n_aw    = m_aw;
    n_xl    = 1'b0;
    if (clear) begin
      n_score = 0;
      n_pend  = 4'b0000;
      n_aw    = 1'b0;
    end else begin
      if (game_over) begin
        n_pend = 4'b0000;
      end else begin
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (!found && m_pend[i]) begin
            found     = 1'b1;
            n_score   = (m_score + pts[i] > MAXV) ? MAXV : m_score + pts[i];
            n_pend[i] = 1'b0;
          end
        end
        n_pend = n_pend | rise;
      end
      if (!m_aw && m_score >= EL) begin
        n_xl = 1'b1;
        n_aw = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      m_score = n_score;
      m_high  = n_high;
      m_pend  = n_pend;
      m_prev  = n_prev;
      m_aw    = n_aw;
      m_xl    = n_xl;
    end
    check_model();
  endtask

  task automatic award(input int ch);
    event_in[ch] = 1'b1;
    tick();
    event_in[ch] = 1'b0;
    tick();
  endtask

  task automatic award_n(input int ch, input int n);
    for (int k = 0; k < n; k++) award(ch);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    game_over = 1'b0;
    event_in  = 4'b0000;
    model_reset();
    #12;
    chk("rst_score", score, 16'h0000);
    chk("rst_high", high_score, 16'h0000);
    chk("rst_xl", {15'd0, extra_life}, 16'h0000);
    chk("rst_sat", {15'd0, saturated}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Single pellet with a held level.
    event_in = 4'b0001;
    tick();
    chk("pellet_busy", {15'd0, busy}, 16'h0001);
    chk("pellet_pre", score, 16'h0000);
    tick();
    chk("pellet_add", score, 16'h0010);
    chk("pellet_idle", {15'd0, busy}, 16'h0000);
    tick();
    tick();
    chk("pellet_held", score, 16'h0010);
    event_in = 4'b0000;
    tick();

    // Simultaneous rises on all channels.
    do_clear();
    event_in = 4'b1111;
    tick();
    event_in = 4'b0000;
    tick(); chk("sim_1", score, 16'h0010);
    tick(); chk("sim_2", score, 16'h0060);
    tick(); chk("sim_3", score, 16'h0260);
    chk("sim_busy3", {15'd0, busy}, 16'h0001);
    tick(); chk("sim_4", score, 16'h0360);
    chk("sim_busy4", {15'd0, busy}, 16'h0000);

    // Carry ripple and saturation.
    do_clear();
    award_n(2, 4); award(3); award(1); award_n(0, 4);
    chk("pre_carry", score, 16'h0990);
    award(0);
    chk("carry", score, 16'h1000);
    tick(); chk("xl_1000", {15'd0, extra_life}, 16'h0001);
    tick(); chk("xl_1000_off", {15'd0, extra_life}, 16'h0000);
    award_n(2, 44); award(3); award(1);
    chk("pre_sat", score, 16'h9950);
    chk("pre_sat_flag", {15'd0, saturated}, 16'h0000);
    award(2);
    chk("sat", score, 16'h9999);
    chk("sat_flag", {15'd0, saturated}, 16'h0001);
    award(0);
    chk("sat_hold", score, 16'h9999);

    // Extra life: once per game, re-armed by clear.
    do_clear();
    award_n(2, 4); award(3); award(1); award(0);
    chk("pre_xl", score, 16'h0960);
    award(3);
    chk("xl_cross", score, 16'h1060);
    chk("xl_not_yet", {15'd0, extra_life}, 16'h0000);
    tick(); chk("xl_pulse", {15'd0, extra_life}, 16'h0001);
    tick(); chk("xl_once", {15'd0, extra_life}, 16'h0000);
    award_n(3, 2);
    tick(); chk("xl_no_second", {15'd0, extra_life}, 16'h0000);
    do_clear();
    award_n(2, 5);
    tick(); chk("xl_new_game", {15'd0, extra_life}, 16'h0001);

    // Asynchronous reset with three requests queued.
    event_in = 4'b0111;
    tick();
    event_in = 4'b0000;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_score", score, 16'h0000);
    chk("arst_high", high_score, 16'h0000);
    chk("arst_busy", {15'd0, busy}, 16'h0000);
    chk("arst_sat", {15'd0, saturated}, 16'h0000);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("arst_no_stale", score, 16'h0000);

    // game_over drops a pending request.
    event_in = 4'b0010;
    tick();
    event_in  = 4'b0000;
    game_over = 1'b1;
    tick();
    chk("go_score", score, 16'h0000);
    chk("go_busy", {15'd0, busy}, 16'h0000);
    game_over = 1'b0;
    tick(); tick();
    chk("go_dropped", score, 16'h0000);

    // High score survives clear and updates one cycle after score.
    event_in = 4'b1111;
    tick();
    event_in = 4'b0000;
    tick(); tick(); tick(); tick();
    chk("hs_0360", score, 16'h0360);
    tick();
    do_clear();
    chk("hs_clr_score", score, 16'h0000);
    chk("hs_kept", high_score, 16'h0360);
    award(2);
    tick();
    chk("hs_0200", high_score, 16'h0360);
    award_n(1, 3); award(0); award(0);
    chk("hs_score_0370", score, 16'h0370);
    chk("hs_lag", high_score, 16'h0360);
    tick();
    chk("hs_update", high_score, 16'h0370);

    // Random phase against the reference model.
    for (int c = 0; c < 400; c++) begin
      event_in  = 4'($urandom);
      game_over = ($urandom_range(15) == 0);
      clear     = ($urandom_range(31) == 0);
      tick();
    end
    event_in  = 4'b0000;
    game_over = 1'b0;
    clear     = 1'b0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
